// File: rtl/mmc1_bank_ctrl.sv
// MMC1 (mapper 01) bank-configuration controller.
// Collects the serial 5-bit CPU writes into the bank registers and drives
// the widened PRG/CHR ROM addresses, CIRAM mirroring and PRG-RAM enable.
// All outputs are combinational from registers and the live bus addresses.
module mmc1_bank_ctrl #(
  parameter logic [4:0] CTRL_RESET         = 5'h0C,
  parameter logic       PRG_RAM_DEFAULT_EN = 1'b1
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        prg_nce_in,
  input  logic [14:0] prg_a_in,
  input  logic        prg_r_nw_in,
  input  logic [7:0]  prg_d_in,
  input  logic [13:0] chr_a_in,
  output logic [17:0] prg_rom_addr,
  output logic [16:0] chr_rom_addr,
  output logic        ciram_a10_out,
  output logic        ciram_nce_out,
  output logic        prg_ram_en_out
);

  logic       wr_now, wr_q, wr_ev;
  logic [4:0] shift;
  logic [2:0] cnt;
  logic [4:0] control, chr0, chr1, prg_reg;
  logic [4:0] load_val;

  // Only bit 7 (serial reset) and bit 0 (serial data) of the bus carry meaning.
  logic unused_d;
  assign unused_d = &{1'b0, prg_d_in[6:1]};

  // A strobe held across several clocks is a single event: detect the rising edge.
  assign wr_now   = ~prg_nce_in & ~prg_r_nw_in;
  assign wr_ev    = wr_now & ~wr_q;
  assign load_val = {prg_d_in[0], shift[4:1]};

  // Serial shift register, bit counter and bank registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      shift   <= 5'd0;
      cnt     <= 3'd0;
      control <= CTRL_RESET;
      chr0    <= 5'd0;
      chr1    <= 5'd0;
      prg_reg <= 5'd0;
    end else begin
      wr_q <= wr_now;
      if (wr_ev) begin
        if (prg_d_in[7]) begin
          // Serial reset: drop partial value and force PRG mode 3.
          shift   <= 5'd0;
          cnt     <= 3'd0;
          control <= control | 5'b01100;
        end else if (cnt == 3'd4) begin
          // Fifth bit: commit to the register picked by the address of this write.
          shift <= 5'd0;
          cnt   <= 3'd0;
          case (prg_a_in[14:13])
            2'b00:   control <= load_val;
            2'b01:   chr0    <= load_val;
            2'b10:   chr1    <= load_val;
            default: prg_reg <= load_val;
          endcase
        end else begin
          shift <= load_val;
          cnt   <= cnt + 3'd1;
        end
      end
    end
  end

  // PRG banking: 32KB switch, or 16KB switch with first/last bank fixed.
  always_comb begin
    prg_rom_addr = '0;
    case (control[3:2])
      2'b10:   prg_rom_addr = prg_a_in[14] ? {prg_reg[3:0], prg_a_in[13:0]}
                                           : {4'h0, prg_a_in[13:0]};
      2'b11:   prg_rom_addr = prg_a_in[14] ? {4'hF, prg_a_in[13:0]}
                                           : {prg_reg[3:0], prg_a_in[13:0]};
      default: prg_rom_addr = {prg_reg[3:1], prg_a_in};
    endcase
  end

  // CHR banking: one 8KB bank or two independent 4KB banks.
  always_comb begin
    chr_rom_addr = '0;
    if (control[4])
      chr_rom_addr = {(chr_a_in[12] ? chr1 : chr0), chr_a_in[11:0]};
    else
      chr_rom_addr = {chr0[4:1], chr_a_in[12:0]};
  end

  // Nametable mirroring select and CIRAM/PRG-RAM enables.
  always_comb begin
    ciram_a10_out = 1'b0;
    case (control[1:0])
      2'b00: ciram_a10_out = 1'b0;
      2'b01: ciram_a10_out = 1'b1;
      2'b10: ciram_a10_out = chr_a_in[10];
      2'b11: ciram_a10_out = chr_a_in[11];
      default: ciram_a10_out = 1'b0;
    endcase
    ciram_nce_out  = ~chr_a_in[13];
    prg_ram_en_out = prg_reg[4] ? 1'b0 : PRG_RAM_DEFAULT_EN;
  end

endmodule

// File: tb/tb_mmc1_bank_ctrl.sv
// Directed bench for mmc1_bank_ctrl: serial writes drive the bank registers,
// probes push expected outputs to a scoreboard and pop them when sampled.
module tb_mmc1_bank_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        prg_nce_in;
  logic [14:0] prg_a_in;
  logic        prg_r_nw_in;
  logic [7:0]  prg_d_in;
  logic [13:0] chr_a_in;
  logic [17:0] prg_rom_addr;
  logic [16:0] chr_rom_addr;
  logic        ciram_a10_out;
  logic        ciram_nce_out;
  logic        prg_ram_en_out;

  typedef struct packed {
    logic [17:0] prg;
    logic [16:0] chr;
    logic        a10;
    logic        nce;
    logic        ram;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  mmc1_bank_ctrl #(.CTRL_RESET(5'h0C), .PRG_RAM_DEFAULT_EN(1'b1)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .prg_nce_in(prg_nce_in), .prg_a_in(prg_a_in), .prg_r_nw_in(prg_r_nw_in),
    .prg_d_in(prg_d_in), .chr_a_in(chr_a_in),
    .prg_rom_addr(prg_rom_addr), .chr_rom_addr(chr_rom_addr),
    .ciram_a10_out(ciram_a10_out), .ciram_nce_out(ciram_nce_out),
    .prg_ram_en_out(prg_ram_en_out)
  );

  always #5 clk_sys = ~clk_sys;

  // One single-clock write strobe followed by one idle clock.
  task automatic write_bit(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    prg_a_in = a; prg_d_in = d; prg_nce_in = 1'b0; prg_r_nw_in = 1'b0;
    @(negedge clk_sys);
    prg_nce_in = 1'b1; prg_r_nw_in = 1'b1;
  endtask

  // Five serial writes, bits[0] first.
  task automatic write5(input logic [14:0] a, input logic [4:0] bits);
    for (int i = 0; i < 5; i++) write_bit(a, {7'd0, bits[i]});
  endtask

  task automatic probe(input string tag, input logic [14:0] p, input logic [13:0] c,
                       input logic [17:0] e_prg, input logic [16:0] e_chr,
                       input logic e_a10, input logic e_nce, input logic e_ram);
    exp_t  e;
    string t;
    @(negedge clk_sys);
    exp_q.push_back('{prg: e_prg, chr: e_chr, a10: e_a10, nce: e_nce, ram: e_ram});
    tag_q.push_back(tag);
    prg_a_in = p; chr_a_in = c;
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert (prg_rom_addr === e.prg) else begin
      fails++; $error("FAIL %s prg_rom_addr got %h want %h", t, prg_rom_addr, e.prg);
    end
    tests++;
    assert (chr_rom_addr === e.chr) else begin
      fails++; $error("FAIL %s chr_rom_addr got %h want %h", t, chr_rom_addr, e.chr);
    end
    tests++;
    assert (ciram_a10_out === e.a10) else begin
      fails++; $error("FAIL %s ciram_a10 got %b want %b", t, ciram_a10_out, e.a10);
    end
    tests++;
    assert (ciram_nce_out === e.nce) else begin
      fails++; $error("FAIL %s ciram_nce got %b want %b", t, ciram_nce_out, e.nce);
    end
    tests++;
    assert (prg_ram_en_out === e.ram) else begin
      fails++; $error("FAIL %s prg_ram_en got %b want %b", t, prg_ram_en_out, e.ram);
    end
  endtask

  initial begin
    rst = 1'b1; prg_nce_in = 1'b1; prg_r_nw_in = 1'b1;
    prg_a_in = '0; prg_d_in = '0; chr_a_in = '0;

    // Reset state and default banking (PRG mode 3, one-screen lower).
    probe("reset", 15'h0000, 14'h0000, 18'h00000, 17'h00000, 1'b0, 1'b1, 1'b1);
    @(negedge clk_sys) rst = 1'b0;
    probe("last_bank", 15'h4000, 14'h0400, 18'h3C000, 17'h00400, 1'b0, 1'b1, 1'b1);
    probe("one_scr_lo", 15'h4000, 14'h2C00, 18'h3C000, 17'h00C00, 1'b0, 1'b0, 1'b1);

    // control = 5'h02: vertical mirroring, 32KB PRG.
    write5(15'h0000, 5'b00010);
    probe("vert_400", 15'h0000, 14'h0400, 18'h00000, 17'h00400, 1'b1, 1'b1, 1'b1);
    probe("vert_800", 15'h0000, 14'h0800, 18'h00000, 17'h00800, 1'b0, 1'b1, 1'b1);

    // Reads and deselected writes of 8'h80 must not touch the registers.
    @(negedge clk_sys);
    prg_a_in = 15'h0000; prg_d_in = 8'h80; prg_nce_in = 1'b0; prg_r_nw_in = 1'b1;
    repeat (3) @(negedge clk_sys);
    prg_nce_in = 1'b1; prg_r_nw_in = 1'b0;
    repeat (3) @(negedge clk_sys);
    prg_r_nw_in = 1'b1; prg_d_in = 8'h00;
    probe("no_write", 15'h4000, 14'h0400, 18'h04000, 17'h00400, 1'b1, 1'b1, 1'b1);

    // Back to PRG mode 3 (control=0x0E), prg_reg=5.
    write_bit(15'h0000, 8'h80);
    write5(15'h6000, 5'b00101);
    probe("prg_sw", 15'h0123, 14'h0000, 18'h14123, 17'h00000, 1'b0, 1'b1, 1'b1);
    probe("prg_fix", 15'h4123, 14'h0000, 18'h3C123, 17'h00000, 1'b0, 1'b1, 1'b1);

    // control=0x10 (4KB CHR, 32KB PRG), chr0=3, chr1=9.
    write5(15'h0000, 5'h10);
    write5(15'h2000, 5'h03);
    write5(15'h4000, 5'h09);
    probe("chr_lo", 15'h0123, 14'h0010, 18'h10123, 17'h03010, 1'b0, 1'b1, 1'b1);
    probe("chr_hi", 15'h0123, 14'h1010, 18'h10123, 17'h09010, 1'b0, 1'b1, 1'b1);

    // Partial sequence aborted by 8'h80, then a clean chr0=1F load.
    write_bit(15'h2000, 8'h01);
    write_bit(15'h2000, 8'h01);
    write_bit(15'h2000, 8'h80);
    probe("abort_mode", 15'h4000, 14'h1010, 18'h3C000, 17'h09010, 1'b0, 1'b1, 1'b1);
    write5(15'h2000, 5'h1F);
    probe("chr0_1f", 15'h0000, 14'h0ABC, 18'h14000, 17'h1FABC, 1'b0, 1'b1, 1'b1);

    // One strobe held for 6 clocks counts as a single bit.
    @(negedge clk_sys);
    prg_a_in = 15'h0000; prg_d_in = 8'h01; prg_nce_in = 1'b0; prg_r_nw_in = 1'b0;
    repeat (6) @(negedge clk_sys);
    prg_nce_in = 1'b1; prg_r_nw_in = 1'b1;
    for (int i = 0; i < 3; i++) write_bit(15'h0000, 8'h00);
    probe("held_4bits", 15'h4000, 14'h0000, 18'h3C000, 17'h1F000, 1'b0, 1'b1, 1'b1);
    write_bit(15'h0000, 8'h00);
    probe("held_5bits", 15'h4000, 14'h0000, 18'h14000, 17'h1E000, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a sequence discards the partial shift.
    write_bit(15'h4000, 8'h01);
    write_bit(15'h4000, 8'h01);
    write_bit(15'h4000, 8'h01);
    @(negedge clk_sys) rst = 1'b1;
    probe("mid_reset", 15'h0000, 14'h0000, 18'h00000, 17'h00000, 1'b0, 1'b1, 1'b1);
    @(negedge clk_sys) rst = 1'b0;
    write5(15'h4000, 5'h16);
    write5(15'h0000, 5'h1C);
    probe("chr1_after", 15'h0000, 14'h1005, 18'h00000, 17'h16005, 1'b0, 1'b1, 1'b1);
    probe("chr0_after", 15'h0000, 14'h0005, 18'h00000, 17'h00005, 1'b0, 1'b1, 1'b1);

    // prg_reg[4] disables PRG-RAM.
    write5(15'h6000, 5'h18);
    probe("ram_off", 15'h0123, 14'h0000, 18'h20123, 17'h00000, 1'b0, 1'b1, 1'b0);
    probe("ram_off_fix", 15'h4123, 14'h2000, 18'h3C123, 17'h00000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmc1_bank_ctrl.md
Name: mmc1_bank_ctrl

Overview:
- Bank-configuration controller for MMC1-class NES cartridges (mapper 01).
- Sits between the CPU/PPU cart bus and the PRG/CHR ROM instances.
- Decodes serial CPU writes to ROM space into internal bank registers.
- Drives widened PRG/CHR ROM addresses, CIRAM mirroring control and the PRG-RAM enable. Contains no ROM itself.

Parameters:
- CTRL_RESET, 5'h0C: control register value at reset (PRG mode 3, one-screen lower mirroring, 8KB CHR).
- PRG_RAM_DEFAULT_EN, 1: value of prg_ram_en_out while prg_reg[4]=0.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- prg_nce_in  in  1  PRG-ROM space select ($8000-$FFFF), active low
- prg_a_in  in  15  CPU address bits 14:0
- prg_r_nw_in  in  1  CPU read/write (0 = write)
- prg_d_in  in  8  CPU write data
- chr_a_in  in  14  PPU address bits 13:0
- prg_rom_addr  out  18  PRG-ROM address (256KB)
- chr_rom_addr  out  17  CHR-ROM address (128KB)
- ciram_a10_out  out  1  CIRAM A10 (mirroring)
- ciram_nce_out  out  1  CIRAM enable, active low
- prg_ram_en_out  out  1  PRG-RAM ($6000) enable, active high

Behaviour:
- Write strobe: wr_now = ~prg_nce_in & ~prg_r_nw_in.
- wr_q is a registered copy of wr_now, reset 0.
- A write event occurs only when wr_now=1 and wr_q=0. A strobe held for N clocks is exactly one event. If the strobe is already high at reset release, it counts as one event on the first clock.
- State: shift[4:0], cnt[2:0] (0..4), control[4:0], chr0[4:0], chr1[4:0], prg_reg[4:0].
- Reset values: shift=0, cnt=0, control=CTRL_RESET, chr0=chr1=prg_reg=0, wr_q=0.
- On a write event with prg_d_in[7]=1:
  - shift and cnt are cleared.
  - control <= control | 5'b01100.
  - Other registers are unchanged.
  - This has priority over everything else.
- On a write event with prg_d_in[7]=0 and cnt<4: shift <= {prg_d_in[0], shift[4:1]}, cnt <= cnt+1.
- On a write event with prg_d_in[7]=0 and cnt=4 (fifth bit):
  - value = {prg_d_in[0], shift[4:1]}.
  - Destination is selected by prg_a_in[14:13]: 00 control, 01 chr0, 10 chr1, 11 prg_reg.
  - shift and cnt are cleared in the same clock.
  - The address is sampled only on the fifth write.
- Updates take effect at the clock edge of the event. All outputs are combinational from registers and current addresses, so new banking is visible immediately after that edge (0 extra latency).
- PRG mapping (P = prg_a_in):
  - control[3:2]=0x: prg_rom_addr = {prg_reg[3:1], P[14:0]} (32KB; prg_reg[0] ignored).
  - =10: P[14]=0 gives {4'h0, P[13:0]}; P[14]=1 gives {prg_reg[3:0], P[13:0]}.
  - =11: P[14]=0 gives {prg_reg[3:0], P[13:0]}; P[14]=1 gives {4'hF, P[13:0]}.
- CHR mapping:
  - control[4]=0: chr_rom_addr = {chr0[4:1], chr_a_in[12:0]}.
  - control[4]=1: chr_rom_addr = {(chr_a_in[12] ? chr1 : chr0), chr_a_in[11:0]}.
- Mirroring control[1:0]:
  - 00: ciram_a10_out=0
  - 01: ciram_a10_out=1
  - 10: ciram_a10_out=chr_a_in[10] (vertical)
  - 11: ciram_a10_out=chr_a_in[11] (horizontal)
- ciram_nce_out = ~chr_a_in[13].
- prg_ram_en_out = prg_reg[4] ? 0 : PRG_RAM_DEFAULT_EN.
- Reads (prg_r_nw_in=1) and accesses with prg_nce_in=1 never change state.
- Reset asserted mid-sequence: partial shift is discarded and all registers return to reset values asynchronously.
- Outputs at reset (chr_a_in=0, P=0): prg_rom_addr=18'h00000, chr_rom_addr=0, ciram_a10_out=0, ciram_nce_out=1, prg_ram_en_out=PRG_RAM_DEFAULT_EN.

Test Plan:
- Reset, then P=15'h4000 -> prg_rom_addr=18'h3C000 (last bank fixed). Mirroring one-screen lower: ciram_a10_out=0 for any chr_a_in.
- Five writes to $8000 with d[0]=0,1,0,0,0 -> control=5'h02. chr_a_in=14'h0400 -> ciram_a10_out=1; chr_a_in=14'h0800 -> ciram_a10_out=0.
- Five writes to $E000 with d[0]=1,0,1,0,0 -> prg_reg=5. With control mode 3, P=15'h0123 -> prg_rom_addr=18'h14123.
- Set control=5'h10, chr0=3, chr1=9 -> chr_a_in=14'h0010 gives chr_rom_addr=17'h03010; chr_a_in=14'h1010 gives chr_rom_addr=17'h09010.
- Two serial bits, then a write of 8'h80, then five bits 1,1,1,1,1 to $A000 -> chr0=5'h1F; control[3:2]=11 after the 8'h80 write.
- Single write strobe held 6 clocks with d[0]=1 -> cnt=1 only. Assert rst after 3 bits, then 5 bits to $C000 -> chr1 equals exactly the last 5 bits.
